avmm_work_loader: RTL and testbench

Synthesizable Avalon-MM master that loads one mining work unit into the miner register file, then optionally monitors it for a result. It accepts a packed work unit (data2 and midstate words) on a valid/ready input and writes each 32-bit word to consecutive register addresses. It then writes a start command and, if enabled, polls status and reads back the found nonce. It sits between the work source (UART/JTAG bridge) and the miner core's Avalon-MM slave.

---
 rtl/fpgaminer_pkg.sv | 24 ++
 rtl/avmm_single_xfer.sv | 56 +++++
 rtl/avmm_work_loader.sv | 211 +++++++++++++++++++++
 tb/tb_avmm_work_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpgaminer_pkg.sv
// Shared types and default register map for the miner work-loading path.
//   loader_state_e : work loader FSM states
//   DEF_*_ADDR     : default miner register-file byte addresses
//   GAP_W          : width of the status-poll gap counter
package fpgaminer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_START,
    ST_POLL,
    ST_POLL_WAIT,
    ST_READ_NONCE,
    ST_RESULT
  } loader_state_e;

  localparam int unsigned DEF_BASE_ADDR   = 'h00;
  localparam int unsigned DEF_CTRL_ADDR   = 'h40;
  localparam int unsigned DEF_STATUS_ADDR = 'h44;
  localparam int unsigned DEF_NONCE_ADDR  = 'h48;

  localparam int unsigned GAP_W = 8;

endpackage

// File: rtl/avmm_single_xfer.sv
// Single Avalon-MM transfer engine with registered bus outputs.
// Accepts a request whenever the bus is free or the current transfer is
// completing, so consecutive requests run back-to-back with no dead cycle.
//   req_valid/req_write/req_addr/req_data : next transfer (sampled when free)
//   done_c   : current transfer completes this cycle
//   rdata_c  : read data, valid with done_c on a read
//   avm_*    : Avalon-MM master signals
module avmm_single_xfer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                done_c,
  output logic [DATA_W-1:0]   rdata_c,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  logic free_c;

  assign done_c  = (avm_write | avm_read) & ~avm_waitrequest;
  assign rdata_c = avm_readdata;
  assign free_c  = ~(avm_write | avm_read) | done_c;

  // Bus registers: hold everything while stalled, reload on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '1;
    end else begin
      avm_byteenable <= '1;
      if (free_c) begin
        avm_write <= req_valid & req_write;
        avm_read  <= req_valid & ~req_write;
        if (req_valid) begin
          avm_address   <= req_addr;
          avm_writedata <= req_data;
        end
      end
    end
  end

endmodule

// File: rtl/avmm_work_loader.sv
// Avalon-MM master that loads one mining work unit into the miner register
// file, writes the start command and optionally polls for a found nonce.
//   work_valid/work_ready/work_data : work unit input (accepted in IDLE only)
//   abort                           : cancel status polling
//   avm_*                           : Avalon-MM master to the miner core
//   res_valid/res_nonce/res_ready   : found-nonce output
//   busy                            : high whenever not IDLE
module avmm_work_loader
  import fpgaminer_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_WORDS   = 16,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned CTRL_ADDR   = DEF_CTRL_ADDR,
  parameter int unsigned STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int unsigned NONCE_ADDR  = DEF_NONCE_ADDR,
  parameter bit          POLL_EN     = 1'b1,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          work_valid,
  output logic                          work_ready,
  input  logic [NUM_WORDS*DATA_W-1:0]   work_data,
  input  logic                          abort,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_write,
  output logic                          avm_read,
  output logic [DATA_W-1:0]             avm_writedata,
  output logic [DATA_W/8-1:0]           avm_byteenable,
  input  logic [DATA_W-1:0]             avm_readdata,
  input  logic                          avm_waitrequest,
  output logic                          res_valid,
  output logic [DATA_W-1:0]             res_nonce,
  input  logic                          res_ready,
  output logic                          busy
);

  localparam int unsigned CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int unsigned WORK_W = NUM_WORDS * DATA_W;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(POLL_GAP);
  localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] NONCE_A  = ADDR_W'(NONCE_ADDR);

  loader_state_e       state, state_n;
  logic [WORK_W-1:0]   work_q;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc_c;
  logic [GAP_W-1:0]    gap, gap_n;
  logic                abort_pend, abort_pend_n;
  logic                accept_c;
  logic                req_valid_c, req_write_c;
  logic [ADDR_W-1:0]   req_addr_c;
  logic [DATA_W-1:0]   req_data_c;
  logic                done_c;
  logic [DATA_W-1:0]   rdata_c;

  // Byte address of data word idx, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] idx);
    logic [31:0] a;
    a = 32'(BASE_ADDR) + (32'(idx) << 2);
    return ADDR_W'(a);
  endfunction

  avmm_single_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid_c),
    .req_write       (req_write_c),
    .req_addr        (req_addr_c),
    .req_data        (req_data_c),
    .done_c          (done_c),
    .rdata_c         (rdata_c),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_read        (avm_read),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  // Next state plus the transfer to issue at the coming edge; issuing on the
  // completing cycle keeps the strobes continuous between transfers.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    gap_n        = gap;
    abort_pend_n = abort_pend;
    req_valid_c  = 1'b0;
    req_write_c  = 1'b0;
    req_addr_c   = '0;
    req_data_c   = '0;
    accept_c     = work_valid & work_ready;
    cnt_inc_c    = cnt + CNT_W'(1);

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_n     = ST_WRITE;
          cnt_n       = '0;
          req_valid_c = 1'b1;
          req_write_c = 1'b1;
          req_addr_c  = word_addr('0);
          req_data_c  = work_data[DATA_W-1:0];
        end
      end
      ST_WRITE: begin
        if (done_c) begin
          req_valid_c = 1'b1;
          req_write_c = 1'b1;
          if (cnt == LAST_IDX) begin
            state_n    = ST_START;
            req_addr_c = CTRL_A;
            req_data_c = DATA_W'(1);
          end else begin
            cnt_n      = cnt_inc_c;
            req_addr_c = word_addr(cnt_inc_c);
            req_data_c = work_q[int'(cnt_inc_c) * int'(DATA_W) +: DATA_W];
          end
        end
      end
      ST_START: begin
        if (done_c) begin
          if (POLL_EN) begin
            state_n      = ST_POLL;
            abort_pend_n = 1'b0;
            req_valid_c  = 1'b1;
            req_addr_c   = STATUS_A;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_POLL: begin
        if (done_c) begin
          abort_pend_n = 1'b0;
          if (abort || abort_pend) begin
            // Status data is discarded when cancelling.
            state_n = ST_IDLE;
          end else if (rdata_c[0]) begin
            state_n     = ST_READ_NONCE;
            req_valid_c = 1'b1;
            req_addr_c  = NONCE_A;
          end else if (POLL_GAP == 0) begin
            req_valid_c = 1'b1;
            req_addr_c  = STATUS_A;
          end else begin
            state_n = ST_POLL_WAIT;
            gap_n   = GAP_INIT;
          end
        end else if (abort) begin
          abort_pend_n = 1'b1;
        end
      end
      ST_POLL_WAIT: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (gap <= GAP_W'(1)) begin
          state_n     = ST_POLL;
          req_valid_c = 1'b1;
          req_addr_c  = STATUS_A;
        end else begin
          gap_n = gap - GAP_W'(1);
        end
      end
      ST_READ_NONCE: begin
        if (done_c) state_n = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      work_q     <= '0;
      cnt        <= '0;
      gap        <= '0;
      abort_pend <= 1'b0;
      work_ready <= 1'b1;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_nonce  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      gap        <= gap_n;
      abort_pend <= abort_pend_n;
      work_ready <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE);
      if (state == ST_IDLE && accept_c) work_q <= work_data;
      if (state == ST_READ_NONCE && done_c) begin
        res_nonce <= rdata_c;
        res_valid <= 1'b1;
      end else if (state == ST_RESULT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avmm_work_loader.sv
// Directed bench for avmm_work_loader: a 16-word polling instance and an
// 8-word non-polling instance, each with a small Avalon slave model.
module tb_avmm_work_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned NW  = 16;
  localparam int unsigned NW8 = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance signals
  logic             work_valid = 1'b0, work_ready;
  logic [NW*DW-1:0] work_data = '0;
  logic             abort = 1'b0;
  logic [AW-1:0]    avm_address;
  logic             avm_write, avm_read;
  logic [DW-1:0]    avm_writedata;
  logic [DW/8-1:0]  avm_byteenable;
  logic [DW-1:0]    avm_readdata = '0;
  logic             avm_waitrequest = 1'b0;
  logic             res_valid, res_ready = 1'b0, busy;
  logic [DW-1:0]    res_nonce;

  // 8-word instance signals
  logic              w8_valid = 1'b0, w8_ready;
  logic [NW8*DW-1:0] w8_data = '0;
  logic [AW-1:0]     b8_address;
  logic              b8_write, b8_read;
  logic [DW-1:0]     b8_writedata;
  logic [DW/8-1:0]   b8_byteenable;
  logic              r8_valid, busy8;
  logic [DW-1:0]     r8_nonce;

  avmm_work_loader #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR('h00), .CTRL_ADDR('h40),
    .STATUS_ADDR('h44), .NONCE_ADDR('h48), .POLL_EN(1'b1), .POLL_GAP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .work_valid(work_valid), .work_ready(work_ready),
    .work_data(work_data), .abort(abort), .avm_address(avm_address),
    .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .res_valid(res_valid), .res_nonce(res_nonce),
    .res_ready(res_ready), .busy(busy)
  );

  avmm_work_loader #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW8), .BASE_ADDR('h00), .CTRL_ADDR('h40),
    .STATUS_ADDR('h44), .NONCE_ADDR('h48), .POLL_EN(1'b0), .POLL_GAP(4)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .work_valid(w8_valid), .work_ready(w8_ready),
    .work_data(w8_data), .abort(1'b0), .avm_address(b8_address),
    .avm_write(b8_write), .avm_read(b8_read), .avm_writedata(b8_writedata),
    .avm_byteenable(b8_byteenable), .avm_readdata(32'h0),
    .avm_waitrequest(1'b0), .res_valid(r8_valid), .res_nonce(r8_nonce),
    .res_ready(1'b0), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_val(input int k, input logic [31:0] seed);
    logic [3:0] n;
    n = 4'(k);
    return {8{n}} ^ seed;
  endfunction

  // Slave model for the main instance
  logic        stall_en = 1'b0;
  int          stall_left = 0;
  bit          in_xfer = 1'b0;
  int          stall_seen = 0;
  int          status_cnt = 0;
  int          ones_after = 0;
  logic [31:0] nonce_val = '0;

  always @(posedge clk) begin
    #1;
    if (avm_write || avm_read) begin
      if (!in_xfer) begin
        stall_left = stall_en ? int'($urandom_range(3, 0)) : 0;
        in_xfer = 1'b1;
      end
      if (stall_left != 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
      end else begin
        avm_waitrequest = 1'b0;
        in_xfer = 1'b0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      in_xfer = 1'b0;
    end
    if (avm_address == 8'h48)      avm_readdata = nonce_val;
    else if (avm_address == 8'h44) avm_readdata = (status_cnt >= ones_after) ? 32'd1 : 32'd0;
    else                           avm_readdata = 32'h0;
  end

  // Bus monitors: completed-transfer logs and stall stability
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic          log_wr[$];
  int            log_cyc[$];
  logic          prev_stalled = 1'b0;
  logic [41:0]   prev_bus = '0;
  logic [41:0]   bus_now;
  assign bus_now = {avm_address, avm_writedata, avm_write, avm_read};

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stalled) check("hold_stable", 64'(bus_now), 64'(prev_bus));
      prev_stalled = (avm_write | avm_read) & avm_waitrequest;
      prev_bus = bus_now;
      if (avm_write || avm_read) begin
        check("rw_exclusive", 64'(avm_write & avm_read), 64'd0);
        if (!avm_waitrequest) begin
          log_addr.push_back(avm_address);
          log_data.push_back(avm_write ? avm_writedata : avm_readdata);
          log_wr.push_back(avm_write);
          log_cyc.push_back(cyc);
          if (avm_read && avm_address == 8'h44) status_cnt++;
        end
      end
    end else begin
      prev_stalled = 1'b0;
    end
  end

  logic [AW-1:0] log8_addr[$];
  logic [31:0]   log8_data[$];
  int            log8_cyc[$];
  int            rd8_seen = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (b8_write) begin
        log8_addr.push_back(b8_address);
        log8_data.push_back(b8_writedata);
        log8_cyc.push_back(cyc);
      end
      if (b8_read) rd8_seen++;
    end
  end

  // Expected transfer sequence
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          exp_wr[$];
  int            exp_cyc[$];

  task automatic build_exp(input logic [31:0] seed, input int hs, input int nw,
                           input int n_status, input bit has_nonce, input logic [31:0] nonce);
    exp_addr.delete(); exp_data.delete(); exp_wr.delete(); exp_cyc.delete();
    for (int k = 0; k < nw; k++) begin
      exp_addr.push_back(8'(4 * k)); exp_data.push_back(word_val(k, seed));
      exp_wr.push_back(1'b1); exp_cyc.push_back(hs + 1 + k);
    end
    exp_addr.push_back(8'h40); exp_data.push_back(32'h1);
    exp_wr.push_back(1'b1); exp_cyc.push_back(hs + nw + 1);
    for (int j = 0; j < n_status; j++) begin
      exp_addr.push_back(8'h44);
      exp_data.push_back((has_nonce && j == n_status - 1) ? 32'h1 : 32'h0);
      exp_wr.push_back(1'b0); exp_cyc.push_back(hs + nw + 2 + 5 * j);
    end
    if (has_nonce) begin
      exp_addr.push_back(8'h48); exp_data.push_back(nonce);
      exp_wr.push_back(1'b0); exp_cyc.push_back(hs + nw + 2 + 5 * (n_status - 1) + 1);
    end
  endtask

  task automatic check_log(input int base, input bit chk_cyc);
    check("xfer_count", 64'(log_addr.size() - base), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (base + i < log_addr.size()) begin
        check($sformatf("xfer_bus[%0d]", i),
              64'({log_wr[base+i], log_addr[base+i], log_data[base+i]}),
              64'({exp_wr[i], exp_addr[i], exp_data[i]}));
        if (chk_cyc)
          check($sformatf("xfer_cycle[%0d]", i), 64'(log_cyc[base+i]), 64'(exp_cyc[i]));
      end
    end
  endtask

  task automatic load_main(input logic [31:0] seed, output int hs);
    @(negedge clk);
    check("load_ready", 64'(work_ready), 64'd1);
    for (int k = 0; k < NW; k++) work_data[k*DW +: DW] = word_val(k, seed);
    work_valid = 1'b1;
    hs = cyc;
    @(posedge clk);
    #1 work_valid = 1'b0;
  endtask

  task automatic wait_res(input int max, output int rc);
    rc = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (res_valid) begin
        rc = cyc;
        break;
      end
    end
    check("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic release_result(input logic [31:0] nonce);
    repeat (3) begin
      @(negedge clk);
      check("res_held_valid", 64'(res_valid), 64'd1);
      check("res_held_nonce", 64'(res_nonce), 64'(nonce));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("res_cleared", 64'(res_valid), 64'd0);
    check("ready_after_res", 64'(work_ready), 64'd1);
    check("busy_after_res", 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, rc, base;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_work_ready", 64'(work_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_read", 64'(avm_read), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_address", 64'(avm_address), 64'd0);
    check("rst_writedata", 64'(avm_writedata), 64'd0);
    check("rst_res_nonce", 64'(res_nonce), 64'd0);
    check("rst_byteenable", 64'(avm_byteenable), 64'hF);
    check("rst_w8_ready", 64'(w8_ready), 64'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unstalled load, two empty polls, nonce found
    ones_after = 2; status_cnt = 0; nonce_val = 32'hDEADBEEF;
    base = log_addr.size();
    load_main(32'h0, hs);
    wait_res(100, rc);
    check("t1_res_cycle", 64'(rc), 64'(hs + 30));
    check("t1_res_nonce", 64'(res_nonce), 64'hDEADBEEF);
    build_exp(32'h0, hs, NW, 3, 1'b1, 32'hDEADBEEF);
    check_log(base, 1'b1);
    release_result(32'hDEADBEEF);

    // Same unit with random stalls on every transfer
    stall_en = 1'b1; stall_seen = 0; ones_after = 2; status_cnt = 0;
    base = log_addr.size();
    load_main(32'h0, hs);
    wait_res(500, rc);
    check("t2_res_nonce", 64'(res_nonce), 64'hDEADBEEF);
    build_exp(32'h0, hs, NW, 3, 1'b1, 32'hDEADBEEF);
    check_log(base, 1'b0);
    check("t2_stalls_seen", 64'(stall_seen != 0), 64'd1);
    release_result(32'hDEADBEEF);
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    // Abort while waiting between status reads
    ones_after = 1000; status_cnt = 0;
    base = log_addr.size();
    load_main(32'hA5A50000, hs);
    while (cyc < hs + 20) @(negedge clk);
    check("t3_in_gap_read", 64'(avm_read), 64'd0);
    check("t3_in_gap_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t3_abort_ready", 64'(work_ready), 64'd1);
    check("t3_abort_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("t3_no_read", 64'(avm_read), 64'd0);
    build_exp(32'hA5A50000, hs, NW, 1, 1'b0, 32'h0);
    check_log(base, 1'b1);

    // Reset while word 5 is on the bus, then a clean reload
    base = log_addr.size();
    load_main(32'h77777777, hs);
    while (cyc < hs + 6) @(negedge clk);
    check("t4_word5_addr", 64'(avm_address), 64'h14);
    check("t4_word5_data", 64'(avm_writedata), 64'(word_val(5, 32'h77777777)));
    #2 reset_n = 1'b0;
    #1;
    check("t4_rst_write", 64'(avm_write), 64'd0);
    check("t4_rst_read", 64'(avm_read), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_ready", 64'(work_ready), 64'd1);
    check("t4_rst_addr", 64'(avm_address), 64'd0);
    check("t4_partial_cnt", 64'(log_addr.size() - base), 64'd6);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ones_after = 0; status_cnt = 0; nonce_val = 32'h0BADF00D;
    base = log_addr.size();
    load_main(32'h3C3C3C3C, hs);
    wait_res(100, rc);
    check("t4_res_cycle", 64'(rc), 64'(hs + 20));
    build_exp(32'h3C3C3C3C, hs, NW, 1, 1'b1, 32'h0BADF00D);
    check_log(base, 1'b1);
    release_result(32'h0BADF00D);

    // Non-polling 8-word instance
    @(negedge clk);
    check("t5_ready", 64'(w8_ready), 64'd1);
    for (int k = 0; k < NW8; k++) w8_data[k*DW +: DW] = word_val(k, 32'h12340000);
    w8_valid = 1'b1;
    hs = cyc;
    @(posedge clk);
    #1 w8_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy8) break;
    end
    check("t5_idle", 64'(busy8), 64'd0);
    check("t5_ready_back", 64'(w8_ready), 64'd1);
    build_exp(32'h12340000, hs, NW8, 0, 1'b0, 32'h0);
    check("t5_count", 64'(log8_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < log8_addr.size()) begin
        check($sformatf("t5_bus[%0d]", i), 64'({log8_addr[i], log8_data[i]}),
              64'({exp_addr[i], exp_data[i]}));
        check($sformatf("t5_cycle[%0d]", i), 64'(log8_cyc[i]), 64'(exp_cyc[i]));
      end
    end
    repeat (5) @(negedge clk);
    check("t5_no_reads", 64'(rd8_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
